// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the sequential chunked adder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of CHUNK-bit slices needed to cover WIDTH bits.
    function automatic int calc_nch(input int width, input int chunk);
        return (chunk > 0) ? (width / chunk) : 1;
    endfunction

    // Slice counter width; never below one bit so NCH=1 still has a counter.
    function automatic int calc_cnt_w(input int width, input int chunk);
        int n;
        n = calc_nch(width, chunk);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// Parametrised combinational ripple carry adder: {cout, s} = a + b + cin.
// Latency: combinational, carry ripples through all WIDTH bit positions.
// Backpressure: none (pure combinational).
// Ports: a, b operands; cin carry-in; s sum; cout carry-out.
module ripple_carry_adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    logic [WIDTH:0] cy;

    assign cy[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign s[i]    = a[i] ^ b[i] ^ cy[i];
        assign cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
    end

    assign cout = cy[WIDTH];

endmodule

// File: rtl/seq_chunk_adder.sv
// Sequential WIDTH-bit add/subtract reusing one CHUNK-bit ripple slice per cycle.
// Latency: NCH = WIDTH/CHUNK cycles from accept edge to out_valid.
// Backpressure: result held until out_ready; new operands accepted in the retire cycle.
// Ports: clk/rst_n; in_valid/in_ready with a, b, c, op_sub; out_valid/out_ready with
//        S (sum/difference), C (carry-out, or NOT borrow for subtract), V (signed overflow).
module seq_chunk_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             C,
    output logic             V
);

    localparam int NCH = calc_nch(WIDTH, CHUNK);
    localparam int CW  = calc_cnt_w(WIDTH, CHUNK);
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
        $error("seq_chunk_adder: need 1 <= CHUNK <= WIDTH and WIDTH a multiple of CHUNK");
    end

    state_t                      state;
    state_t                      state_nxt;
    logic [NCH-1:0][CHUNK-1:0]   a_r;
    logic [NCH-1:0][CHUNK-1:0]   b_r;
    logic [NCH-1:0][CHUNK-1:0]   s_r;
    logic                        carry_r;
    logic [CW-1:0]               cnt;
    logic                        c_r;
    logic                        v_r;
    logic [CHUNK-1:0]            a_sl;
    logic [CHUNK-1:0]            b_sl;
    logic [CHUNK-1:0]            s_sl;
    logic                        cout_sl;
    logic                        last;
    logic                        accept;

    assign a_sl   = a_r[cnt];
    assign b_sl   = b_r[cnt];
    assign last   = (cnt == LAST);
    assign accept = in_valid && in_ready;

    ripple_carry_adder #(
        .WIDTH (CHUNK)
    ) u_slice (
        .a    (a_sl),
        .b    (b_sl),
        .cin  (carry_r),
        .s    (s_sl),
        .cout (cout_sl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                // Retire and accept can share a cycle, giving back-to-back operation.
                in_ready  = out_ready;
                if (out_ready) begin
                    state_nxt = in_valid ? RUN : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            s_r     <= '0;
            carry_r <= 1'b0;
            cnt     <= '0;
            c_r     <= 1'b0;
            v_r     <= 1'b0;
        end else if (accept) begin
            // Subtract as a + ~b + ~c, so the slice only ever adds.
            a_r     <= a;
            b_r     <= op_sub ? ~b : b;
            carry_r <= op_sub ? ~c : c;
            cnt     <= '0;
        end else if (state == RUN) begin
            s_r[cnt] <= s_sl;
            carry_r  <= cout_sl;
            cnt      <= cnt + 1'b1;
            if (last) begin
                c_r <= cout_sl;
                // Overflow when both addends share a sign the result does not.
                v_r <= (a_r[NCH-1][CHUNK-1] == b_r[NCH-1][CHUNK-1]) &&
                       (s_sl[CHUNK-1] != a_r[NCH-1][CHUNK-1]);
            end
        end
    end

    assign S = s_r;
    assign C = c_r;
    assign V = v_r;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench for seq_chunk_adder: directed corners, backpressure,
// mid-operation reset, and a randomized sweep at CHUNK=64 and CHUNK=1.
module tb_seq_chunk_adder;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n;

    logic         in_valid, in_ready, c, op_sub, out_valid, out_ready, C, V;
    logic [W-1:0] a, b, S;

    logic         sw_valid, sw_c, sw_sub, sw_ordy;
    logic [W-1:0] sw_a, sw_b;
    logic         r1_ir, r1_ov, r1_C, r1_V;
    logic [W-1:0] r1_S;
    logic         r64_ir, r64_ov, r64_C, r64_V;
    logic [W-1:0] r64_S;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } res_t;

    always #5 clk = ~clk;

    seq_chunk_adder #(.WIDTH(W), .CHUNK(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .op_sub(op_sub), .out_valid(out_valid),
        .out_ready(out_ready), .S(S), .C(C), .V(V)
    );

    seq_chunk_adder #(.WIDTH(W), .CHUNK(64)) u_n1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r1_ir),
        .a(sw_a), .b(sw_b), .c(sw_c), .op_sub(sw_sub), .out_valid(r1_ov),
        .out_ready(sw_ordy), .S(r1_S), .C(r1_C), .V(r1_V)
    );

    seq_chunk_adder #(.WIDTH(W), .CHUNK(1)) u_n64 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r64_ir),
        .a(sw_a), .b(sw_b), .c(sw_c), .op_sub(sw_sub), .out_valid(r64_ov),
        .out_ready(sw_ordy), .S(r64_S), .C(r64_C), .V(r64_V)
    );

    // Golden model: exact integer arithmetic on widened operands.
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic sub);
        res_t         r;
        logic [W+1:0] u;
        logic [W+1:0] sg;
        logic [W+1:0] sx;
        logic [W+1:0] sy;
        logic [W+1:0] cw;
        sx = {{2{x[W-1]}}, x};
        sy = {{2{y[W-1]}}, y};
        cw = (W+2)'(ci);
        if (!sub) begin
            u   = {2'b00, x} + {2'b00, y} + cw;
            r.c = u[W];
            sg  = sx + sy + cw;
        end else begin
            u   = {2'b00, x} - {2'b00, y} - cw;
            r.c = ~u[W+1];
            sg  = sx - sy - cw;
        end
        r.s = u[W-1:0];
        r.v = !((sg[W+1:W-1] == 3'b000) || (sg[W+1:W-1] == 3'b111));
        return r;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b0, {(W-1){1'b1}}};
            3:       return {1'b1, {(W-1){1'b0}}};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for out_valid on the main DUT; returns cycles since the accept edge.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic main_op(input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic ci, input logic sub, input string tag);
        res_t e;
        int   n;
        e        = model(x, y, ci, sub);
        a        = x;
        b        = y;
        c        = ci;
        op_sub   = sub;
        in_valid = 1'b1;
        chk({tag, " in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        a        = {$urandom, $urandom};
        b        = {$urandom, $urandom};
        c        = ~ci;
        op_sub   = ~sub;
        wait_valid(n);
        chk({tag, " latency"}, n, 4);
        chk({tag, " S"}, S, e.s);
        chk({tag, " C"}, C, e.c);
        chk({tag, " V"}, V, e.v);
        tick();
        chk({tag, " retired"}, out_valid, 0);
    endtask

    initial begin
        res_t         e1;
        res_t         e2;
        int           n;
        int           n1;
        int           n64;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         ci;
        logic         sub;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        c         = 1'b0;
        op_sub    = 1'b0;
        out_ready = 1'b1;
        sw_valid  = 1'b0;
        sw_a      = '0;
        sw_b      = '0;
        sw_c      = 1'b0;
        sw_sub    = 1'b0;
        sw_ordy   = 1'b1;
        tick();
        tick();

        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset S", S, 0);
        chk("reset C", C, 0);
        chk("reset V", V, 0);
        rst_n = 1'b1;
        tick();

        main_op('1, 64'd1, 1'b0, 1'b0, "carry_chain");
        chk("carry_chain S const", S, 0);
        chk("carry_chain C const", C, 1);
        main_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, "ovf_add");
        chk("ovf_add V const", V, 1);
        main_op(64'd0, 64'd1, 1'b0, 1'b1, "sub_0_1");
        chk("sub_0_1 S const", S, '1);
        chk("sub_0_1 C const", C, 0);
        main_op(64'd5, 64'd3, 1'b0, 1'b1, "sub_5_3");
        chk("sub_5_3 S const", S, 2);
        chk("sub_5_3 C const", C, 1);

        // Backpressure then same-cycle retire and accept.
        out_ready = 1'b0;
        x  = {$urandom, $urandom};
        y  = {$urandom, $urandom};
        e1 = model(x, y, 1'b1, 1'b0);
        a = x; b = y; c = 1'b1; op_sub = 1'b0; in_valid = 1'b1;
        tick();
        x  = {$urandom, $urandom};
        y  = {$urandom, $urandom};
        e2 = model(x, y, 1'b0, 1'b1);
        a = x; b = y; c = 1'b0; op_sub = 1'b1;
        wait_valid(n);
        chk("bp latency", n, 4);
        for (int k = 0; k < 5; k++) begin
            chk("bp S held", S, e1.s);
            chk("bp C held", C, e1.c);
            chk("bp V held", V, e1.v);
            chk("bp in_ready low", in_ready, 0);
            chk("bp out_valid high", out_valid, 1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("b2b in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        a = '0; b = '0;
        chk("b2b first retired", out_valid, 0);
        wait_valid(n);
        chk("b2b latency", n, 4);
        chk("b2b S", S, e2.s);
        chk("b2b C", C, e2.c);
        chk("b2b V", V, e2.v);
        tick();

        // Reset in the middle of a computation (cnt == 2).
        a = '1; b = '1; c = 1'b1; op_sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst in_ready", in_ready, 1);
        chk("midrst out_valid", out_valid, 0);
        chk("midrst S", S, 0);
        chk("midrst C", C, 0);
        tick();
        rst_n = 1'b1;
        tick();
        main_op(64'd3, 64'd4, 1'b0, 1'b0, "after_rst");
        chk("after_rst S const", S, 7);
        chk("after_rst C const", C, 0);

        for (int i = 0; i < 20; i++) begin
            main_op(pick(), pick(), 1'($urandom), 1'($urandom), "rand16");
        end

        // Sweep: both extreme slicings run the same operands side by side.
        for (int i = 0; i < 1000; i++) begin
            x   = pick();
            y   = pick();
            ci  = 1'($urandom);
            sub = 1'($urandom);
            e1  = model(x, y, ci, sub);
            sw_a = x; sw_b = y; sw_c = ci; sw_sub = sub; sw_valid = 1'b1;
            tick();
            sw_valid = 1'b0;
            sw_a = {$urandom, $urandom};
            sw_b = {$urandom, $urandom};
            sw_c = ~ci;
            sw_sub = ~sub;
            n   = 0;
            n1  = -1;
            n64 = -1;
            while (n64 < 0 && n < 100) begin
                tick();
                n++;
                if (r1_ov && n1 < 0) begin
                    n1 = n;
                    chk("nch1 S", r1_S, e1.s);
                    chk("nch1 C", r1_C, e1.c);
                    chk("nch1 V", r1_V, e1.v);
                end
                if (r64_ov) begin
                    n64 = n;
                    chk("nch64 S", r64_S, e1.s);
                    chk("nch64 C", r64_C, e1.c);
                    chk("nch64 V", r64_V, e1.v);
                end
            end
            chk("nch1 latency", n1, 1);
            chk("nch64 latency", n64, 64);
        end
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
- Multi-cycle, area-reduced successor to the combinational n-bit ripple carry adder.
- Computes a WIDTH-bit add or subtract with one CHUNK-bit ripple slice, reused over WIDTH/CHUNK cycles; the carry is registered between slices.
- Valid/ready handshakes on input and output let it sit in a datapath stream where ripple depth across the full WIDTH would break timing.

Parameters:
WIDTH  64  operand and result width in bits
CHUNK  16  bits processed per cycle; WIDTH % CHUNK == 0 and 1 <= CHUNK <= WIDTH (elaboration-time check, $error otherwise)

Ports:
clk        input   1      clock, rising edge
rst_n      input   1      reset, asynchronous assert, active-low
in_valid   input   1      operands valid
in_ready   output  1      block can accept operands
a          input   WIDTH  operand A
b          input   WIDTH  operand B
c          input   1      carry-in (add) / borrow-in (sub)
op_sub     input   1      0: a+b+c; 1: a-b-c
out_valid  output  1      result valid
out_ready  input   1      consumer accepts result
S          output  WIDTH  sum/difference
C          output  1      carry-out (add) / NOT borrow-out (sub)
V          output  1      signed two's-complement overflow

Behaviour:
- Clock and reset: one clock. rst_n is asynchronous, active-low.
- Reset values: state IDLE, in_ready=1, out_valid=0, S=0, C=0, V=0, chunk counter=0, carry register=0.
- NCH = WIDTH/CHUNK. The counter is max($clog2(NCH),1) bits wide.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, register a into a_r. Register b_r = op_sub ? ~b : b.
  - Set carry register = op_sub ? ~c : c. Set cnt=0. Go to RUN.
- RUN:
  - in_ready=0. Each cycle, slice k=cnt computes {cout, s} = a_r[k*CHUNK +: CHUNK] + b_r[same] + carry.
  - Write s into S[k*CHUNK +: CHUNK]. Set carry <= cout. Set cnt <= cnt+1.
  - On cnt==NCH-1:
    - C <= cout.
    - V <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (s[CHUNK-1] != a_r[WIDTH-1]).
    - Go to DONE, out_valid <= 1.
- DONE:
  - out_valid=1. S, C and V are held stable until out_ready=1.
  - in_ready = out_ready. This allows back-to-back operation: if out_valid && out_ready && in_valid in the same cycle, the result retires and the new operands are captured. Go directly to RUN, out_valid <= 0.
  - If out_ready && !in_valid: go to IDLE, out_valid <= 0.
- Latency: from the accept edge to out_valid high is NCH cycles. For NCH=1, out_valid rises on the cycle after accept.
- Throughput: one result per NCH+1 cycles with out_ready held high.
- Operands and the mode are captured only at accept. Changes on a, b, c or op_sub after accept have no effect.
- in_valid while in_ready=0 is ignored. The producer must hold its data until it is accepted.
- Mid-operation reset: an asynchronous rst_n assertion in any state returns immediately to reset values. The partial result is discarded.
- During RUN, S holds a mix of new low chunks and old high chunks. Consumers use S only while out_valid=1.
- Subtraction semantics: C=1 means no borrow. 0-1 gives S=all ones, C=0.

Decomposition:
- Shared package adder_pkg holds:
  - the state enum (IDLE/RUN/DONE)
  - the localparam function computing NCH and the counter width
- One natural sub-module: the CHUNK-bit slice adder. Instantiate the team's existing parametrised ripple carry adder module with width=CHUNK. No new fa-level logic.

Test Plan:
- WIDTH=64, CHUNK=16, add: a=64'hFFFF_FFFF_FFFF_FFFF, b=1, c=0 -> out_valid exactly 4 cycles after accept; S=0, C=1, V=0. Verifies carry propagation across every chunk boundary.
- Signed overflow, add: a=64'h7FFF_FFFF_FFFF_FFFF, b=1 -> S=64'h8000_0000_0000_0000, C=0, V=1.
- Subtract: a=0, b=1, c=0, op_sub=1 -> S=all ones, C=0, V=0. Then a=5, b=3, op_sub=1 -> S=2, C=1.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles after out_valid -> S, C, V stable and in_ready=0.
  - Then raise out_ready together with a new in_valid -> same-cycle retire and accept. The second result is correct 4 cycles later.
- Reset mid-RUN: drop rst_n at cnt==2 -> in_ready=1, out_valid=0, S=0, C=0 immediately. The next operation 3+4 gives S=7, C=0.
- Parameter sweep: CHUNK=64 (NCH=1) and CHUNK=1 (NCH=64) on 1000 random a, b, c, op_sub -> results match the golden {C,S} model with latency NCH.
